nmi_bus_arbiter: RTL and testbench
==================================

// Module: nmi_bus_arbiter
// PURPOSE
//  Two-master arbiter sharing one NMI slave port: m0 = CPU, m1 = DMA engine (the peripheral block's DMA master).
//  Its s_* side drives the native peripheral wrapper's NMI slave.
//  Registered grant with round-robin or fixed priority, grant held for the whole transaction.
//  A per-transaction timeout watchdog ends hung accesses with an error response.
// PARAMETERS
//  PRIO_MODE    0     0 = round-robin between m0/m1; 1 = fixed priority, m0 always wins
//  TMO_W        10    width of timeout counter
//  TMO_CYC      1023  cycles in BUSY without s_ready before abort (1..2^TMO_W-1)
//  TMO_RDATA    32'hDEAD_BEEF  rdata returned on a timed-out access
// PORTS
//  clk_i        in   1   system clock
//  rst_n_i      in   1   async active-low reset
//  m0_valid_i   in   1   CPU request; held high until m0_ready_o
//  m0_addr_i    in   32  CPU address
//  m0_wdata_i   in   32  CPU write data
//  m0_wstrb_i   in   4   CPU byte strobes (0 = read)
//  m0_ready_o   out  1   1-cycle completion pulse to CPU
//  m0_rdata_o   out  32  read data, valid when m0_ready_o
//  m1_*         -    -   DMA port, identical set to m0_*
//  s_valid_o    out  1   request to shared slave
//  s_addr_o     out  32  muxed address
//  s_wdata_o    out  32  muxed write data
//  s_wstrb_o    out  4   muxed strobes
//  s_ready_i    in   1   slave completion
//  s_rdata_i    in   32  slave read data
//  tmo_clr_i    in   1   clears tmo_sticky_o
//  tmo_pulse_o  out  1   1-cycle pulse when a timeout abort occurs
//  tmo_sticky_o out  1   set on timeout, cleared by tmo_clr_i (set wins if same cycle)
// BEHAVIOUR
//  Reset: state=IDLE, gnt=none, rr_last=m1 (so m0 wins first tie), tmo_cnt=0; all outputs 0.
//  FSM IDLE: s_valid_o=0. If any mX_valid_i: latch gnt (reg), tmo_cnt<=0, -> BUSY next cycle.
//   Tie: PRIO_MODE=0 -> master != rr_last; PRIO_MODE=1 -> m0.
//  BUSY: s_valid_o = gnt master's valid; s_addr/wdata/wstrb = gnt master's (combinational mux).
//   Non-granted master: ready_o=0, rdata_o=0; its valid stays pending.
//   s_ready_i & s_valid_o: gnt ready_o=1, rdata_o=s_rdata_i same cycle; rr_last<=gnt; -> IDLE.
//   No s_ready_i: tmo_cnt++; when tmo_cnt==TMO_CYC-1 and still no ready: s_valid_o forced 0
//    next cycle (ABORT), gnt ready_o=1 with rdata_o=TMO_RDATA that cycle, tmo_pulse_o=1,
//    tmo_sticky_o<=1, rr_last<=gnt, -> IDLE. Timeout latency = TMO_CYC+1 cycles after grant.
//   gnt master drops valid in BUSY (protocol violation): abandon, no ready, -> IDLE.
//  ABORT is a 1-cycle state; s_ready_i arriving in ABORT is ignored.
//  Min cost per access: 1 arb cycle + slave latency + 1 IDLE cycle; back-to-back same master OK.
//  s_* outputs outside BUSY: valid=0, addr/wdata/wstrb=0.
//  Async reset mid-transaction: all state cleared immediately; in-flight access lost, no ready.
//  rdata_o/ready_o of both masters are never simultaneously 1.
// TESTING
//  1 m0 read 0x1000_1000, slave ready after 3 cycles, rdata 0x55 -> m0_ready_o on 5th cycle after request, rdata 0x55.
//  2 m0,m1 valid together, PRIO_MODE=0, 4 rounds -> grant order m0,m1,m0,m1; PRIO_MODE=1 -> m0 x4 while m0 held.
//  3 m1 write 0x4000_0000 wdata 0xA5A5 wstrb 0xF while m0 requests mid-access -> s_* stay on m1 until ready; m0 next.
//  4 TMO_CYC=8, slave never ready -> m0_ready_o at cycle 9 after grant, rdata 0xDEAD_BEEF, tmo_pulse_o 1, sticky 1.
//  5 tmo_clr_i with sticky=1 -> 0 next cycle; clr coincident with new timeout -> sticky stays 1.
//  6 assert rst_n_i low during BUSY -> s_valid_o 0 at once; after release m0 wins first tie.

Source files
------------

// File: rtl/nmi_bus_arbiter_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// nmi_bus_arbiter_if
// One NMI request/response channel.
//
// The requester drives valid/addr/wdata/wstrb and holds them until it sees
// ready. The responder pulses ready for one cycle, with rdata valid in that
// same cycle. A wstrb of 0 means a read.
//
// Signals:
//   valid  requester -> responder  request pending
//   addr   requester -> responder  32-bit address
//   wdata  requester -> responder  32-bit write data
//   wstrb  requester -> responder  byte strobes
//   ready  responder -> requester  one-cycle completion pulse
//   rdata  responder -> requester  read data, valid when ready
//
// Modports:
//   master  the side that issues requests
//   slave   the side that answers them
// ---------------------------------------------------------------------------
interface nmi_bus_arbiter_if;
   logic        valid;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        ready;
   logic [31:0] rdata;

   modport master (output valid, addr, wdata, wstrb, input ready, rdata);
   modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/nmi_bus_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// nmi_bus_arbiter
// Lets two masters share one NMI slave. m0 is the CPU and m1 is the DMA
// engine. The grant is registered and stays with one master for the whole
// transaction. A watchdog ends any access that hangs and returns an error
// data word instead.
//
// Parameters:
//   PRIO_MODE  0 = round-robin between m0 and m1
//              1 = fixed priority, where m0 always wins
//   TMO_W      width of the timeout counter
//   TMO_CYC    number of BUSY cycles without s.ready before the access is
//              aborted (1 .. 2^TMO_W-1)
//   TMO_RDATA  rdata returned on an aborted access
//
// Ports:
//   clk_i         system clock
//   rst_n_i       asynchronous reset, active low
//   m0            CPU channel (slave modport)
//   m1            DMA channel (slave modport)
//   s             shared slave channel (master modport)
//   tmo_clr_i     clears tmo_sticky_o
//   tmo_pulse_o   one-cycle pulse in the cycle a timeout abort completes
//   tmo_sticky_o  set by a timeout and cleared by tmo_clr_i; if both happen
//                 in the same cycle, the set wins
// ---------------------------------------------------------------------------
module nmi_bus_arbiter #(
   parameter int          PRIO_MODE = 0,
   parameter int          TMO_W     = 10,
   parameter int          TMO_CYC   = 1023,
   parameter logic [31:0] TMO_RDATA = 32'hDEAD_BEEF
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   nmi_bus_arbiter_if.slave  m0,
   nmi_bus_arbiter_if.slave  m1,
   nmi_bus_arbiter_if.master s,
   input  logic              tmo_clr_i,
   output logic              tmo_pulse_o,
   output logic              tmo_sticky_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_ABORT = 2'd2
   } state_t;

   // tmo_cnt reaches this value on the last BUSY cycle that is still allowed
   // to complete normally.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

   state_t           state_q, state_d;
   logic             gnt_q, gnt_d;           // 0 = m0, 1 = m1
   logic             rr_last_q, rr_last_d;   // master served most recently
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             tmo_sticky_q, tmo_sticky_d;

   logic             gnt_valid;
   logic             pick;
   logic             resp_ready;
   logic [31:0]      resp_rdata;

   // Choose the winner for the next grant. When both masters request,
   // round-robin favours the one that was not served last. Reset sets
   // rr_last to m1, so m0 wins the first tie.
   always_comb begin
      gnt_valid = gnt_q ? m1.valid : m0.valid;
      if (m0.valid && m1.valid) begin
         pick = (PRIO_MODE != 0) ? 1'b0 : ~rr_last_q;
      end else begin
         pick = m1.valid & ~m0.valid;
      end
   end

   // The shared slave sees the granted master only while in BUSY. At all
   // other times every s.* output is driven to zero.
   always_comb begin
      s.valid = 1'b0;
      s.addr  = '0;
      s.wdata = '0;
      s.wstrb = '0;
      if (state_q == ST_BUSY) begin
         s.valid = gnt_valid;
         s.addr  = gnt_q ? m1.addr  : m0.addr;
         s.wdata = gnt_q ? m1.wdata : m0.wdata;
         s.wstrb = gnt_q ? m1.wstrb : m0.wstrb;
      end
   end

   // Route the response to the granted master only. A normal completion
   // passes s.ready and s.rdata straight through in the same cycle. In
   // ABORT the response comes from registered state, and any s.ready that
   // arrives during ABORT has no effect.
   always_comb begin
      resp_ready = 1'b0;
      resp_rdata = '0;
      if (state_q == ST_BUSY && gnt_valid && s.ready) begin
         resp_ready = 1'b1;
         resp_rdata = s.rdata;
      end else if (state_q == ST_ABORT) begin
         resp_ready = 1'b1;
         resp_rdata = TMO_RDATA;
      end
      m0.ready = resp_ready & ~gnt_q;
      m0.rdata = (resp_ready & ~gnt_q) ? resp_rdata : '0;
      m1.ready = resp_ready & gnt_q;
      m1.rdata = (resp_ready & gnt_q) ? resp_rdata : '0;
   end

   // Next-state logic for the transaction FSM.
   // - If the granted master drops valid during BUSY, the access is
   //   abandoned. No ready is returned and rr_last is left unchanged.
   // - The watchdog counts only the BUSY cycles in which no s.ready arrives.
   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      rr_last_d    = rr_last_q;
      tmo_cnt_d    = tmo_cnt_q;
      tmo_sticky_d = tmo_sticky_q & ~tmo_clr_i;
      unique case (state_q)
         ST_IDLE: begin
            if (m0.valid || m1.valid) begin
               gnt_d     = pick;
               tmo_cnt_d = '0;
               state_d   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (!gnt_valid) begin
               state_d = ST_IDLE;
            end else if (s.ready) begin
               rr_last_d = gnt_q;
               state_d   = ST_IDLE;
            end else if (tmo_cnt_q == TMO_LAST) begin
               state_d = ST_ABORT;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end
         ST_ABORT: begin
            rr_last_d    = gnt_q;
            tmo_sticky_d = 1'b1;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers. Reset clears everything at once, so an access that
   // is in flight at that moment is dropped without a response.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= ST_IDLE;
         gnt_q        <= 1'b0;
         rr_last_q    <= 1'b1;
         tmo_cnt_q    <= '0;
         tmo_sticky_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         rr_last_q    <= rr_last_d;
         tmo_cnt_q    <= tmo_cnt_d;
         tmo_sticky_q <= tmo_sticky_d;
      end
   end

   assign tmo_pulse_o  = (state_q == ST_ABORT);
   assign tmo_sticky_o = tmo_sticky_q;

endmodule

// File: tb/tb_nmi_bus_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_nmi_bus_arbiter
// Directed bench for nmi_bus_arbiter.
//
// dut_a: round-robin arbitration, TMO_CYC = 8. Every cycle its outputs are
//        compared against a transaction-level model.
// dut_b: fixed priority. Checked with a short run of literal expectations.
// ---------------------------------------------------------------------------
module tb_nmi_bus_arbiter;

   localparam int          TMO      = 8;
   localparam logic [31:0] TMO_DATA = 32'hDEAD_BEEF;

   logic clk_i = 1'b0;
   logic rst_n_i;
   logic tmo_clr_i;
   logic tmo_pulse_o, tmo_sticky_o;
   logic tmo_pulse_b, tmo_sticky_b;

   nmi_bus_arbiter_if m0_if ();
   nmi_bus_arbiter_if m1_if ();
   nmi_bus_arbiter_if s_if ();
   nmi_bus_arbiter_if m0b_if ();
   nmi_bus_arbiter_if m1b_if ();
   nmi_bus_arbiter_if sb_if ();

   int n_checks = 0;
   int n_errors = 0;
   int served_q[$];

   // Slave behaviour. slave_lat >= 0 raises ready once s.valid has been
   // waiting for that many cycles. -1 means ready never comes. -2 drives a
   // stray ready whenever s.valid is low.
   int   slave_lat = 0;
   int   slave_cnt = 0;
   logic sv_seen, sr_seen;

   nmi_bus_arbiter #(
      .PRIO_MODE (0), .TMO_W (10), .TMO_CYC (TMO), .TMO_RDATA (TMO_DATA)
   ) dut_a (
      .clk_i (clk_i), .rst_n_i (rst_n_i),
      .m0 (m0_if), .m1 (m1_if), .s (s_if),
      .tmo_clr_i (tmo_clr_i), .tmo_pulse_o (tmo_pulse_o), .tmo_sticky_o (tmo_sticky_o)
   );

   nmi_bus_arbiter #(
      .PRIO_MODE (1), .TMO_W (10), .TMO_CYC (1023), .TMO_RDATA (TMO_DATA)
   ) dut_b (
      .clk_i (clk_i), .rst_n_i (rst_n_i),
      .m0 (m0b_if), .m1 (m1b_if), .s (sb_if),
      .tmo_clr_i (1'b0), .tmo_pulse_o (tmo_pulse_b), .tmo_sticky_o (tmo_sticky_b)
   );

   // 10 ns clock.
   always #5 clk_i = ~clk_i;

   // Hard stop in case anything hangs.
   initial begin
      #100000;
      $display("[TB] FAIL global_timeout actual=running required=finished");
      $fatal(1, "[TB] simulation did not finish");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic get_ready(input int m);
      return (m == 0) ? m0_if.ready : m1_if.ready;
   endfunction

   function automatic logic [31:0] get_rdata(input int m);
      return (m == 0) ? m0_if.rdata : m1_if.rdata;
   endfunction

   task automatic drive_master(input int m, input logic v, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] st);
      if (m == 0) begin
         m0_if.valid = v; m0_if.addr = a; m0_if.wdata = d; m0_if.wstrb = st;
      end else begin
         m1_if.valid = v; m1_if.addr = a; m1_if.wdata = d; m1_if.wstrb = st;
      end
   endtask

   // Start this task just after a rising edge. It holds the request until
   // ready appears, reports how many cycles that took (0 = the request
   // cycle), and drops valid just after the following rising edge.
   task automatic applyStimulus(input int m, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] st, output logic [31:0] rd,
                                output int lat, output logic pulse);
      drive_master(m, 1'b1, a, d, st);
      lat   = -1;
      rd    = '0;
      pulse = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_i);
         if (get_ready(m)) begin
            lat   = i;
            rd    = get_rdata(m);
            pulse = tmo_pulse_o;
            break;
         end
      end
      if (lat < 0) begin
         n_checks++;
         n_errors++;
         $display("[TB] FAIL handshake_m%0d actual=no_ready required=ready", m);
      end
      @(posedge clk_i);
      #1;
      drive_master(m, 1'b0, '0, '0, '0);
   endtask

   // Sample the slave-side handshake in the middle of each cycle.
   always @(negedge clk_i) begin
      sv_seen = s_if.valid;
      sr_seen = s_if.ready;
   end

   // Drive the slave response for the new cycle, 2 ns after the rising edge.
   // This is after the masters have updated their requests.
   always @(posedge clk_i) begin
      #2;
      if (sv_seen && !sr_seen) slave_cnt++;
      else slave_cnt = 0;
      if (slave_lat >= 0) s_if.ready = s_if.valid && (slave_cnt >= slave_lat);
      else if (slave_lat == -2) s_if.ready = !s_if.valid;
      else s_if.ready = 1'b0;
   end

   // Transaction-level model of dut_a.
   //   owner  the master holding the grant, or -1 when the bus is free
   //   age    number of waiting cycles elapsed; when age reaches TMO, that
   //          cycle is the abort response
   // The model is checked against the DUT outputs on every falling edge.
   int          mdl_owner  = -1;
   int          mdl_age    = 0;
   int          mdl_last   = 1;
   logic        mdl_sticky = 1'b0;
   int          nxt_owner, nxt_age, nxt_last;
   logic        set_sticky;
   logic        mv[2];
   logic [31:0] ma[2], md[2];
   logic [3:0]  ms[2];
   logic        exp_sv, exp_pulse, exp_sticky;
   logic [31:0] exp_sa, exp_sd;
   logic [3:0]  exp_ss;
   logic        exp_rdy[2];
   logic [31:0] exp_rd[2];

   always @(negedge clk_i) begin
      mv[0] = m0_if.valid; ma[0] = m0_if.addr; md[0] = m0_if.wdata; ms[0] = m0_if.wstrb;
      mv[1] = m1_if.valid; ma[1] = m1_if.addr; md[1] = m1_if.wdata; ms[1] = m1_if.wstrb;
      if (!rst_n_i) begin
         mdl_owner = -1; mdl_age = 0; mdl_last = 1; mdl_sticky = 1'b0;
      end
      exp_sv = 0; exp_sa = 0; exp_sd = 0; exp_ss = 0; exp_pulse = 0;
      exp_rdy[0] = 0; exp_rdy[1] = 0; exp_rd[0] = 0; exp_rd[1] = 0;
      exp_sticky = mdl_sticky;
      nxt_owner = mdl_owner; nxt_age = mdl_age; nxt_last = mdl_last; set_sticky = 0;
      if (rst_n_i) begin
         if (mdl_owner < 0) begin
            if (mv[0] || mv[1]) begin
               nxt_owner = (mv[0] && mv[1]) ? 1 - mdl_last : (mv[0] ? 0 : 1);
               nxt_age   = 0;
            end
         end else if (mdl_age == TMO) begin
            exp_rdy[mdl_owner] = 1;
            exp_rd[mdl_owner]  = TMO_DATA;
            exp_pulse  = 1;
            set_sticky = 1;
            nxt_last   = mdl_owner;
            nxt_owner  = -1;
         end else begin
            exp_sa = ma[mdl_owner]; exp_sd = md[mdl_owner]; exp_ss = ms[mdl_owner];
            if (!mv[mdl_owner]) begin
               nxt_owner = -1;
            end else begin
               exp_sv = 1;
               if (s_if.ready) begin
                  exp_rdy[mdl_owner] = 1;
                  exp_rd[mdl_owner]  = s_if.rdata;
                  nxt_last  = mdl_owner;
                  nxt_owner = -1;
               end else begin
                  nxt_age = mdl_age + 1;
               end
            end
         end
      end
      checkOutput("s_valid", s_if.valid, exp_sv);
      checkOutput("s_addr", s_if.addr, exp_sa);
      checkOutput("s_wdata", s_if.wdata, exp_sd);
      checkOutput("s_wstrb", s_if.wstrb, exp_ss);
      checkOutput("m0_ready", m0_if.ready, exp_rdy[0]);
      checkOutput("m0_rdata", m0_if.rdata, exp_rd[0]);
      checkOutput("m1_ready", m1_if.ready, exp_rdy[1]);
      checkOutput("m1_rdata", m1_if.rdata, exp_rd[1]);
      checkOutput("tmo_pulse", tmo_pulse_o, exp_pulse);
      checkOutput("tmo_sticky", tmo_sticky_o, exp_sticky);
      if (rst_n_i) begin
         mdl_owner  = nxt_owner;
         mdl_age    = nxt_age;
         mdl_last   = nxt_last;
         mdl_sticky = set_sticky | (mdl_sticky & !tmo_clr_i);
      end
      if (m0_if.ready) served_q.push_back(0);
      if (m1_if.ready) served_q.push_back(1);
   end

   // Directed test sequence.
   logic [31:0] rd_a, rd_b;
   int          lat_a, lat_b;
   logic        pls_a, pls_b;
   int          b_m0, b_m1;
   int          rr_exp[4] = '{0, 1, 0, 1};

   task automatic applyReset();
      rst_n_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #3;
      rst_n_i = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_n_i = 1'b0; tmo_clr_i = 1'b0;
      drive_master(0, 0, '0, '0, '0);
      drive_master(1, 0, '0, '0, '0);
      s_if.ready = 0; s_if.rdata = 32'h0000_0055;
      m0b_if.valid = 0; m0b_if.addr = 32'h10; m0b_if.wdata = 0; m0b_if.wstrb = 0;
      m1b_if.valid = 0; m1b_if.addr = 32'h20; m1b_if.wdata = 0; m1b_if.wstrb = 0;
      sb_if.ready = 1; sb_if.rdata = 32'h0000_1234;

      // Outputs during reset.
      @(negedge clk_i);
      checkOutput("reset_s_valid", s_if.valid, 1'b0);
      checkOutput("reset_m0_ready", m0_if.ready, 1'b0);
      checkOutput("reset_sticky", tmo_sticky_o, 1'b0);
      applyReset();

      // Test 1: m0 read; the slave answers after 3 cycles.
      slave_lat = 3; s_if.rdata = 32'h0000_0055;
      applyStimulus(0, 32'h1000_1000, '0, 4'h0, rd_a, lat_a, pls_a);
      checkOutput("t1_latency", lat_a, 4);
      checkOutput("t1_rdata", rd_a, 32'h0000_0055);

      // Test 2: both masters always requesting, two rounds each.
      applyReset();
      slave_lat = 1; served_q.delete();
      fork
         begin
            applyStimulus(0, 32'h0000_0100, '0, 4'h0, rd_a, lat_a, pls_a);
            applyStimulus(0, 32'h0000_0104, '0, 4'h0, rd_a, lat_a, pls_a);
         end
         begin
            applyStimulus(1, 32'h0000_0200, 32'h11, 4'h1, rd_b, lat_b, pls_b);
            applyStimulus(1, 32'h0000_0204, 32'h22, 4'h3, rd_b, lat_b, pls_b);
         end
      join
      checkOutput("t2_order_len", served_q.size(), 4);
      for (int i = 0; i < 4 && i < served_q.size(); i++)
         checkOutput("t2_order", served_q[i], rr_exp[i]);

      // Test 2b: fixed priority with both requests held continuously.
      b_m0 = 0; b_m1 = 0;
      m0b_if.valid = 1; m1b_if.valid = 1;
      repeat (8) begin
         @(negedge clk_i);
         if (m0b_if.ready) b_m0++;
         if (m1b_if.ready) b_m1++;
      end
      @(posedge clk_i); #1;
      m0b_if.valid = 0; m1b_if.valid = 0;
      checkOutput("t2b_m0_grants", b_m0, 4);
      checkOutput("t2b_m1_grants", b_m1, 0);

      // Test 3: m1 write; m0 requests partway through the access.
      slave_lat = 3; served_q.delete();
      fork
         applyStimulus(1, 32'h4000_0000, 32'h0000_A5A5, 4'hF, rd_b, lat_b, pls_b);
         begin
            repeat (2) @(posedge clk_i);
            #1;
            applyStimulus(0, 32'h1000_2000, '0, 4'h0, rd_a, lat_a, pls_a);
         end
      join
      checkOutput("t3_m1_latency", lat_b, 4);
      checkOutput("t3_order_len", served_q.size(), 2);
      if (served_q.size() == 2) begin
         checkOutput("t3_first", served_q[0], 1);
         checkOutput("t3_second", served_q[1], 0);
      end

      // Test 4: the slave never answers, so the watchdog aborts the access.
      slave_lat = -1;
      applyStimulus(0, 32'h1000_3000, '0, 4'h0, rd_a, lat_a, pls_a);
      checkOutput("t4_latency", lat_a, TMO + 1);
      checkOutput("t4_rdata", rd_a, 32'hDEAD_BEEF);
      checkOutput("t4_pulse", pls_a, 1'b1);
      @(negedge clk_i);
      checkOutput("t4_sticky", tmo_sticky_o, 1'b1);

      // Test 5: clear the sticky flag, then clear again in the same cycle
      // as a new abort. Stray ready pulses during ABORT must be ignored.
      @(posedge clk_i); #1;
      tmo_clr_i = 1'b1;
      @(posedge clk_i); #1;
      tmo_clr_i = 1'b0;
      @(negedge clk_i);
      checkOutput("t5_sticky_cleared", tmo_sticky_o, 1'b0);
      @(posedge clk_i); #1;
      slave_lat = -2; tmo_clr_i = 1'b1;
      applyStimulus(1, 32'h4000_0010, '0, 4'h0, rd_b, lat_b, pls_b);
      tmo_clr_i = 1'b0;
      checkOutput("t5_latency", lat_b, TMO + 1);
      checkOutput("t5_rdata", rd_b, 32'hDEAD_BEEF);
      @(negedge clk_i);
      checkOutput("t5_sticky_set_wins", tmo_sticky_o, 1'b1);

      // Abandon: m0 drops valid while BUSY, so no response may follow.
      @(posedge clk_i); #1;
      slave_lat = -1; served_q.delete();
      drive_master(0, 1, 32'h1000_4000, '0, 4'h0);
      repeat (3) @(posedge clk_i);
      #1;
      drive_master(0, 0, '0, '0, '0);
      repeat (4) @(negedge clk_i);
      checkOutput("abandon_no_ready", served_q.size(), 0);
      checkOutput("abandon_s_valid", s_if.valid, 1'b0);

      // Test 6: complete one m0 access so that m1 would win the next tie.
      // Then reset during an m1 access.
      @(posedge clk_i); #1;
      slave_lat = 0;
      applyStimulus(0, 32'h1000_5000, '0, 4'h0, rd_a, lat_a, pls_a);
      checkOutput("t6_pre_latency", lat_a, 1);
      slave_lat = -1;
      drive_master(1, 1, 32'h4000_0020, '0, 4'h0);
      repeat (2) @(posedge clk_i);
      #3;
      checkOutput("t6_busy_before_reset", s_if.valid, 1'b1);
      rst_n_i = 1'b0;
      #1;
      checkOutput("t6_s_valid_in_reset", s_if.valid, 1'b0);
      checkOutput("t6_m1_ready_in_reset", m1_if.ready, 1'b0);
      drive_master(1, 0, '0, '0, '0);
      repeat (2) @(posedge clk_i);
      #3;
      rst_n_i = 1'b1;
      @(posedge clk_i); #1;
      slave_lat = 1; served_q.delete();
      fork
         applyStimulus(0, 32'h1000_6000, '0, 4'h0, rd_a, lat_a, pls_a);
         applyStimulus(1, 32'h4000_0030, '0, 4'h0, rd_b, lat_b, pls_b);
      join
      checkOutput("t6_order_len", served_q.size(), 2);
      if (served_q.size() == 2) begin
         checkOutput("t6_first_tie", served_q[0], 0);
         checkOutput("t6_second", served_q[1], 1);
      end

      repeat (2) @(posedge clk_i);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
